// File: rtl/msrv32_decode_queue.sv
// rtl/msrv32_decode_queue.sv - msrv32 decode stage with a DEPTH-entry decoded-instruction FIFO.
// Optional M-extension decode is enabled by defining MSRV32_MDU_EN.
module msrv32_decode_queue #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_in,
  input  logic                       flush_in,
  input  logic                       instr_valid_in,
  output logic                       instr_ready_out,
  input  logic [31:0]                instr_in,
  input  logic [PC_W-1:0]            pc_in,
  output logic                       dec_valid_out,
  input  logic                       dec_ready_in,
  output logic [PC_W-1:0]            pc_out,
  output logic [4:0]                 rs1_addr_out,
  output logic [4:0]                 rs2_addr_out,
  output logic [4:0]                 rd_addr_out,
  output logic [2:0]                 wb_mux_sel_out,
  output logic [2:0]                 imm_type_out,
  output logic [3:0]                 alu_opcode_out,
  output logic                       alu_src_out,
  output logic                       iadder_src_out,
  output logic                       rf_wr_en_out,
  output logic                       csr_wr_en_out,
  output logic [2:0]                 csr_op_out,
  output logic                       mem_rd_out,
  output logic                       mem_wr_out,
  output logic [1:0]                 load_size_out,
  output logic                       load_unsigned_out,
  output logic                       illegal_instr_out,
  output logic                       muldiv_out,
  output logic [$clog2(DEPTH):0]     occupancy_out
);

  localparam int AW = $clog2(DEPTH);

`ifdef MSRV32_MDU_EN
  localparam logic MDU = 1'b1;
`else
  localparam logic MDU = 1'b0;
`endif

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      wb_mux_sel;
    logic [2:0]      imm_type;
    logic [3:0]      alu_opcode;
    logic            alu_src;
    logic            iadder_src;
    logic            rf_wr_en;
    logic            csr_wr_en;
    logic [2:0]      csr_op;
    logic            mem_rd;
    logic            mem_wr;
    logic [1:0]      load_size;
    logic            load_unsigned;
    logic            illegal;
    logic            muldiv;
  } entry_t;

  entry_t      dec;
  entry_t      head;
  entry_t      mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ill;
  logic       wr_req;
  logic       csr_req;
  logic       ld_req;
  logic       st_req;
  logic       md;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  always_comb begin
    dec     = '0;
    ill     = 1'b0;
    wr_req  = 1'b0;
    csr_req = 1'b0;
    ld_req  = 1'b0;
    st_req  = 1'b0;
    md      = 1'b0;
    dec.pc            = pc_in;
    dec.rs1           = instr_in[19:15];
    dec.rs2           = instr_in[24:20];
    dec.rd            = instr_in[11:7];
    dec.csr_op        = funct3;
    dec.load_size     = funct3[1:0];
    dec.load_unsigned = funct3[2];
    dec.alu_opcode    = {1'b0, funct3};
    // Full 7-bit match so opcode[1:0] != 11 falls into the illegal default.
    case (opcode)
      7'b0110011: begin
        md = MDU && (funct7 == 7'b0000001);
        dec.alu_opcode = {funct7[5], funct3};
        dec.alu_src    = 1'b1;
        wr_req         = 1'b1;
        ill = !((funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) || md);
      end
      7'b0010011: begin
        dec.imm_type   = 3'b001;
        dec.alu_opcode = {(funct3 == 3'b101) & funct7[5], funct3};
        wr_req         = 1'b1;
        ill = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
              (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000);
      end
      7'b0000011: begin
        dec.wb_mux_sel = 3'b001;
        dec.imm_type   = 3'b001;
        dec.iadder_src = 1'b1;
        wr_req         = 1'b1;
        ld_req         = 1'b1;
        ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b0100011: begin
        dec.imm_type   = 3'b010;
        dec.iadder_src = 1'b1;
        st_req         = 1'b1;
        ill = (funct3 > 3'b010);
      end
      7'b1100011: begin
        dec.imm_type = 3'b011;
        ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      7'b1100111: begin
        dec.wb_mux_sel = 3'b101;
        dec.imm_type   = 3'b001;
        dec.iadder_src = 1'b1;
        wr_req         = 1'b1;
        ill = (funct3 != 3'b000);
      end
      7'b1101111: begin
        dec.wb_mux_sel = 3'b101;
        dec.imm_type   = 3'b101;
        wr_req         = 1'b1;
      end
      7'b0110111: begin
        dec.wb_mux_sel = 3'b010;
        dec.imm_type   = 3'b100;
        wr_req         = 1'b1;
      end
      7'b0010111: begin
        dec.wb_mux_sel = 3'b011;
        dec.imm_type   = 3'b100;
        wr_req         = 1'b1;
      end
      7'b0001111: begin
        dec.imm_type = 3'b001;
      end
      7'b1110011: begin
        dec.wb_mux_sel = 3'b100;
        dec.imm_type   = 3'b110;
        csr_req        = (funct3 != 3'b000) && (funct3 != 3'b100);
        wr_req         = csr_req;
        ill = (funct3 == 3'b100);
      end
      default: ill = 1'b1;
    endcase
    dec.illegal   = ill;
    dec.muldiv    = md;
    dec.rf_wr_en  = wr_req & (dec.rd != 5'd0) & ~ill;
    dec.csr_wr_en = csr_req & ~ill;
    dec.mem_rd    = ld_req & ~ill;
    dec.mem_wr    = st_req & ~ill;
  end

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign push  = instr_valid_in & ~full & ~flush_in;
  assign pop   = ~empty & dec_ready_in & ~flush_in;

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_in) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Payload storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) mem[wptr[AW-1:0]] <= dec;
  end

  assign head            = empty ? '0 : mem[rptr[AW-1:0]];
  assign instr_ready_out = ~full;
  assign dec_valid_out   = ~empty;
  assign occupancy_out   = wptr - rptr;

  assign pc_out            = head.pc;
  assign rs1_addr_out      = head.rs1;
  assign rs2_addr_out      = head.rs2;
  assign rd_addr_out       = head.rd;
  assign wb_mux_sel_out    = head.wb_mux_sel;
  assign imm_type_out      = head.imm_type;
  assign alu_opcode_out    = head.alu_opcode;
  assign alu_src_out       = head.alu_src;
  assign iadder_src_out    = head.iadder_src;
  assign rf_wr_en_out      = head.rf_wr_en;
  assign csr_wr_en_out     = head.csr_wr_en;
  assign csr_op_out        = head.csr_op;
  assign mem_rd_out        = head.mem_rd;
  assign mem_wr_out        = head.mem_wr;
  assign load_size_out     = head.load_size;
  assign load_unsigned_out = head.load_unsigned;
  assign illegal_instr_out = head.illegal;
  assign muldiv_out        = head.muldiv;

endmodule

// File: tb/tb_msrv32_decode_queue.sv
// tb/tb_msrv32_decode_queue.sv - randomized self-checking bench for msrv32_decode_queue.
// Honours MSRV32_MDU_EN in its reference decoder.
module tb_msrv32_decode_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] pc_o;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  wb, imm, csr_op;
  logic [3:0]  alu;
  logic        alu_src, iadder_src, rf_wr, csr_wr, mem_rd, mem_wr, ld_uns, ill, md;
  logic [1:0]  ld_size;
  logic [1:0]  occ;

  msrv32_decode_queue #(.PC_W(32), .DEPTH(DEPTH)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush),
    .instr_valid_in(instr_valid), .instr_ready_out(instr_ready), .instr_in(instr), .pc_in(pc),
    .dec_valid_out(dec_valid), .dec_ready_in(dec_ready), .pc_out(pc_o),
    .rs1_addr_out(rs1), .rs2_addr_out(rs2), .rd_addr_out(rd),
    .wb_mux_sel_out(wb), .imm_type_out(imm), .alu_opcode_out(alu), .alu_src_out(alu_src),
    .iadder_src_out(iadder_src), .rf_wr_en_out(rf_wr), .csr_wr_en_out(csr_wr), .csr_op_out(csr_op),
    .mem_rd_out(mem_rd), .mem_wr_out(mem_wr), .load_size_out(ld_size), .load_unsigned_out(ld_uns),
    .illegal_instr_out(ill), .muldiv_out(md), .occupancy_out(occ)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  wb, imm;
    logic [3:0]  alu;
    logic        alu_src, iadder, rf, csr_wr;
    logic [2:0]  csr_op;
    logic        mem_rd, mem_wr;
    logic [1:0]  ls;
    logic        lu, ill, md;
  } dec_t;

  int tests = 0;
  int fails = 0;
  logic [63:0] q[$];
  logic        last_push;
  logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h0F, 7'h73};

`ifdef MSRV32_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  function automatic dec_t ref_dec(logic [31:0] i, logic [31:0] p);
    dec_t d;
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    bit wr = 0, csr = 0, ldq = 0, stq = 0, bad = 0;
    d = '0;
    d.pc = p; d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7];
    d.csr_op = f3; d.ls = f3[1:0]; d.lu = f3[2]; d.alu = {1'b0, f3};
    case (i[6:0])
      7'h33: begin
        d.md = MDU && f7 == 7'h01;
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) || d.md);
        d.alu = {f7[5], f3}; d.alu_src = 1; wr = 1;
      end
      7'h13: begin
        d.imm = 1; wr = 1;
        if (f3 == 3'd5) d.alu[3] = f7[5];
        bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
      end
      7'h03: begin d.wb = 1; d.imm = 1; d.iadder = 1; wr = 1; ldq = 1; bad = f3 inside {3'd3, 3'd6, 3'd7}; end
      7'h23: begin d.imm = 2; d.iadder = 1; stq = 1; bad = f3 > 3'd2; end
      7'h63: begin d.imm = 3; bad = f3 inside {3'd2, 3'd3}; end
      7'h67: begin d.wb = 5; d.imm = 1; d.iadder = 1; wr = 1; bad = f3 != 3'd0; end
      7'h6F: begin d.wb = 5; d.imm = 5; wr = 1; end
      7'h37: begin d.wb = 2; d.imm = 4; wr = 1; end
      7'h17: begin d.wb = 3; d.imm = 4; wr = 1; end
      7'h0F: d.imm = 1;
      7'h73: begin d.wb = 4; d.imm = 6; csr = !(f3 inside {3'd0, 3'd4}); wr = csr; bad = f3 == 3'd4; end
      default: bad = 1;
    endcase
    d.ill = bad;
    d.rf = wr && d.rd != 0 && !bad;
    d.csr_wr = csr && !bad;
    d.mem_rd = ldq && !bad;
    d.mem_wr = stq && !bad;
    return d;
  endfunction

  function automatic dec_t dut_out();
    dec_t d;
    d.pc = pc_o; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.wb = wb; d.imm = imm; d.alu = alu;
    d.alu_src = alu_src; d.iadder = iadder_src; d.rf = rf_wr; d.csr_wr = csr_wr; d.csr_op = csr_op;
    d.mem_rd = mem_rd; d.mem_wr = mem_wr; d.ls = ld_size; d.lu = ld_uns; d.ill = ill; d.md = md;
    return d;
  endfunction

  function automatic dec_t model_head();
    if (q.size() == 0) return '0;
    return ref_dec(q[0][63:32], q[0][31:0]);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int sel = $urandom_range(0, 11);
    if (sel < 11) r[6:0] = ops[sel];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  task automatic tick();
    bit pu, po;
    pu = instr_valid && q.size() < DEPTH && !flush;
    po = q.size() > 0 && dec_ready && !flush;
    @(posedge clk);
    last_push = pu;
    if (flush) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back({instr, pc});
    end
    #1;
  endtask

  task automatic push_one(logic [31:0] i, logic [31:0] p);
    instr_valid = 1; instr = i; pc = p;
    tick();
    instr_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", dec_valid); end
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    tests++; if (occ !== 2'd0) begin fails++; $display("FAIL reset_occ got=%0d exp=0", occ); end
    tests++; if (dut_out() !== dec_t'(0)) begin fails++; $display("FAIL reset_fields got=%h exp=0", dut_out()); end
    rst = 0;
    q.delete();
  endtask

  task automatic test_addi();
    push_one(32'h00500093, 32'h100);
    tests++; if (dec_valid !== 1'b1) begin fails++; $display("FAIL addi_valid got=%b exp=1", dec_valid); end
    tests++;
    if ({rd, wb, imm, alu, alu_src, rf_wr} !== {5'd1, 3'b000, 3'b001, 4'b0000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL addi_fields got=%h exp=%h", {rd, wb, imm, alu, alu_src, rf_wr}, {5'd1, 3'b000, 3'b001, 4'b0000, 1'b0, 1'b1});
    end
    tests++; if (dut_out() !== model_head()) begin fails++; $display("FAIL addi_model got=%h exp=%h", dut_out(), model_head()); end
    dec_ready = 1; tick(); dec_ready = 0;
  endtask

  task automatic test_sub_lw();
    push_one(32'h402081B3, 32'h200);
    push_one(32'h0000A103, 32'h204);
    tests++; if ({alu, alu_src, rd} !== {4'b1000, 1'b1, 5'd3}) begin fails++; $display("FAIL sub_fields got=%h exp=%h", {alu, alu_src, rd}, {4'b1000, 1'b1, 5'd3}); end
    tests++; if (dut_out() !== model_head()) begin fails++; $display("FAIL sub_model got=%h exp=%h", dut_out(), model_head()); end
    dec_ready = 1; tick(); dec_ready = 0;
    tests++;
    if ({wb, mem_rd, ld_size, iadder_src, pc_o} !== {3'b001, 1'b1, 2'b10, 1'b1, 32'h204}) begin
      fails++; $display("FAIL lw_fields got=%h exp=%h", {wb, mem_rd, ld_size, iadder_src, pc_o}, {3'b001, 1'b1, 2'b10, 1'b1, 32'h204});
    end
    dec_ready = 1; tick(); dec_ready = 0;
  endtask

  task automatic test_illegal_x0();
    push_one(32'h00000000, 32'h300);
    push_one(32'h00000013, 32'h304);
    tests++;
    if ({ill, rf_wr, csr_wr, mem_rd, mem_wr} !== 5'b10000) begin
      fails++; $display("FAIL zero_instr got=%b exp=10000", {ill, rf_wr, csr_wr, mem_rd, mem_wr});
    end
    dec_ready = 1; tick(); dec_ready = 0;
    tests++; if ({ill, rf_wr} !== 2'b00) begin fails++; $display("FAIL addi_x0 got=%b exp=00", {ill, rf_wr}); end
    dec_ready = 1; tick(); dec_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] order[$];
    int n = 0;
    dec_ready = 0;
    instr_valid = 1;
    instr = 32'h00500013 | (32'd5 << 7); pc = 32'h400; tick();
    instr = 32'h00500013 | (32'd6 << 7); pc = 32'h404; tick();
    instr = 32'h00500013 | (32'd7 << 7); pc = 32'h408; tick();
    tests++; if ({instr_ready, occ} !== {1'b0, 2'd2}) begin fails++; $display("FAIL full_state got=%b/%0d exp=0/2", instr_ready, occ); end
    tests++; if (last_push !== 1'b0) begin fails++; $display("FAIL full_accepted got=%b exp=0", last_push); end
    dec_ready = 1;
    while (n < 20 && (instr_valid || q.size() != 0)) begin
      if (dec_valid) order.push_back(rd);
      tests++; if (dut_out() !== model_head()) begin fails++; $display("FAIL drain_model got=%h exp=%h", dut_out(), model_head()); end
      tick();
      if (last_push) instr_valid = 0;
      n++;
    end
    dec_ready = 0;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL third_accept got=pending exp=accepted"); end
    tests++;
    if (order.size() != 3 || order[0] !== 5'd5 || order[1] !== 5'd6 || order[2] !== 5'd7) begin
      fails++; $display("FAIL fifo_order got=%p exp=5,6,7", order);
    end
  endtask

  task automatic test_flush();
    push_one(32'h00100093, 32'h500);
    push_one(32'h00200093, 32'h504);
    instr_valid = 1; instr = 32'h00300093; flush = 1; dec_ready = 1;
    tick();
    flush = 0; instr_valid = 0; dec_ready = 0;
    tests++; if ({dec_valid, occ} !== {1'b0, 2'd0}) begin fails++; $display("FAIL flush_full got=%b/%0d exp=0/0", dec_valid, occ); end
    push_one(32'h00100093, 32'h600);
    instr_valid = 1; instr = 32'h00300093; flush = 1;
    tick();
    flush = 0; instr_valid = 0;
    tests++; if ({dec_valid, occ, rd} !== {1'b0, 2'd0, 5'd0}) begin fails++; $display("FAIL flush_push got=%b/%0d/%0d exp=0/0/0", dec_valid, occ, rd); end
    tick();
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL flush_discard got=%b exp=0", dec_valid); end
  endtask

  task automatic test_async_reset();
    push_one(32'h00700093, 32'h700);
    #2 rst = 1;
    #1;
    q.delete();
    tests++; if ({dec_valid, occ, instr_ready} !== {1'b0, 2'd0, 1'b1}) begin fails++; $display("FAIL async_rst_state got=%b exp=001", {dec_valid, occ, instr_ready}); end
    tests++; if (dut_out() !== dec_t'(0)) begin fails++; $display("FAIL async_rst_fields got=%h exp=0", dut_out()); end
    #1 rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    push_one(32'h023100B3, 32'h800);
    tests++;
    if ({md, ill, rf_wr} !== (MDU ? 3'b101 : 3'b010)) begin
      fails++; $display("FAIL mul got=%b exp=%b", {md, ill, rf_wr}, (MDU ? 3'b101 : 3'b010));
    end
    tests++; if (dut_out() !== model_head()) begin fails++; $display("FAIL mul_model got=%h exp=%h", dut_out(), model_head()); end
    dec_ready = 1; tick(); dec_ready = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      instr_valid = ($urandom_range(0, 9) < 6);
      dec_ready   = ($urandom_range(0, 1) == 1);
      flush       = ($urandom_range(0, 15) == 0);
      instr       = rand_instr();
      pc          = $urandom;
      tests++;
      if ({dec_valid, instr_ready, occ} !== {q.size() != 0, q.size() != DEPTH, 2'(q.size())}) begin
        fails++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c, {dec_valid, instr_ready, occ}, {q.size() != 0, q.size() != DEPTH, 2'(q.size())});
      end
      tests++; if (dut_out() !== model_head()) begin fails++; $display("FAIL rand_fields cyc=%0d got=%h exp=%h", c, dut_out(), model_head()); end
      tick();
    end
    instr_valid = 0; dec_ready = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub_lw();
    test_illegal_x0();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msrv32_decode_queue.md
Name: msrv32_decode_queue

Overview:
- Registered, parametrised decode stage for the pipelined msrv32 core, placed between fetch and execute.
- Accepts raw 32-bit instructions with their PC over a valid/ready handshake and decodes them fully, including register addresses, control fields and a complete illegal-instruction check.
- Decoded entries are buffered in a DEPTH-entry FIFO so fetch and execute are decoupled.
- A flush input discards all buffered entries on a trap or redirect.

Parameters:
- PC_W, 32, width of pc_in/pc_out.
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- ms_riscv32_mp_clk_in  in  1  clock; all state updates on its rising edge
- ms_riscv32_mp_rst_in  in  1  asynchronous active-high reset
- flush_in  in  1  synchronous queue flush (trap taken / redirect)
- instr_valid_in  in  1  instr_in/pc_in valid
- instr_ready_out  out  1  queue can accept
- instr_in  in  32  raw instruction
- pc_in  in  PC_W  instruction PC
- dec_valid_out  out  1  head entry valid
- dec_ready_in  in  1  execute consumes head
- pc_out  out  PC_W  head PC
- rs1_addr_out, rs2_addr_out, rd_addr_out  out  5 each  register indices
- wb_mux_sel_out  out  3  000 ALU, 001 load, 010 imm (LUI), 011 iadder (AUIPC), 100 CSR, 101 PC+4 (JAL/JALR)
- imm_type_out  out  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 CSR
- alu_opcode_out  out  4  {funct7[5] if OP, or OP-IMM with funct3=101, else 0; funct3}
- alu_src_out  out  1  1 = rs2 (OP), 0 = immediate
- iadder_src_out  out  1  1 = rs1 base (JALR/load/store), 0 = PC
- rf_wr_en_out  out  1  register-file write
- csr_wr_en_out  out  1  SYSTEM with funct3 != 000 and funct3 != 100
- csr_op_out  out  3  funct3
- mem_rd_out, mem_wr_out  out  1 each  load / store
- load_size_out  out  2  funct3[1:0]
- load_unsigned_out  out  1  funct3[2]
- illegal_instr_out  out  1  entry is illegal
- muldiv_out  out  1  M-extension op (see Optional Feature)
- occupancy_out  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (async, active-high): pointers and count go to 0. dec_valid_out=0, occupancy_out=0, instr_ready_out=1. All decoded outputs read 0.
- Decode is combinational on instr_in. Decoded fields are written into the FIFO entry on a push.
- Push = instr_valid_in & instr_ready_out & !flush_in.
- Pop = dec_valid_out & dec_ready_in & !flush_in.
- instr_ready_out = (count != DEPTH); it is not combinationally dependent on dec_ready_in.
- Latency: an instruction pushed into an empty queue appears on the outputs with dec_valid_out=1 on the next cycle.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push and pop are handled identically when the queue is full or empty.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
- Full = MSB differs and low bits are equal. Empty = pointers equal.
- All decoded outputs are forced to 0 while dec_valid_out=0.
- The head entry is held stable while dec_valid_out=1 and dec_ready_in=0.
- Flush: on the next edge, count and both pointers go to 0. Any push or pop in the flush cycle is ignored. dec_valid_out=0 the following cycle.
- Flush has priority over push and pop. Reset has priority over everything.
- rf_wr_en_out=1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC and CSR ops, and is forced 0 when rd=0.
- illegal_instr_out=1 for any of the following:
  - opcode[1:0] != 11, or an unknown opcode[6:2].
  - LOAD with funct3 in {011, 110, 111}.
  - STORE with funct3 > 010.
  - BRANCH with funct3 in {010, 011}.
  - JALR with funct3 != 000.
  - OP with funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not in {000, 101}.
  - OP-IMM shifts (funct3 001/101) with an invalid funct7.
  - SYSTEM with funct3=100.
- Illegal entries still occupy a slot. Their rf_wr_en_out, csr_wr_en_out, mem_rd_out and mem_wr_out are forced to 0.
- MISC-MEM (FENCE) is legal and decodes as a no-op: all enables 0.

Optional Feature:
- Macro MSRV32_MDU_EN.
- Defined: OP with funct7=0000001 is legal. It sets muldiv_out=1, rf_wr_en_out per rd, wb_mux_sel_out=000 and alu_opcode_out={0, funct3}.
- Undefined: that encoding is illegal, and muldiv_out is tied to 0.

Test Plan:
- ADDI x1,x0,5 (0x00500093) into empty queue -> next cycle dec_valid_out=1, rd=1, wb=000, imm=001, alu=0000, alu_src=0, rf_wr_en=1.
- SUB x3,x1,x2 (0x402081B3) then LW x2,0(x1) (0x0000A103) -> SUB: alu=1000, alu_src=1; LW: wb=001, mem_rd=1, load_size=10, iadder_src=1.
- 0x00000000 and 0x00000093 with rd forced to x0 -> first: illegal=1, all enables 0; ADDI x0: rf_wr_en=0, illegal=0.
- DEPTH=2, dec_ready_in=0, push 3 back-to-back -> 2 accepted, instr_ready_out=0, occupancy=2. Raise dec_ready_in -> FIFO order preserved, third accepted.
- Full queue plus flush_in pulse with a concurrent push -> next cycle occupancy=0, dec_valid_out=0, pushed instruction discarded. Async reset asserted mid-stream -> outputs 0 immediately.
- MUL x1,x2,x3 (0x023100B3) -> with MSRV32_MDU_EN: muldiv=1, illegal=0, rf_wr_en=1; without it: illegal=1, muldiv=0.
